// File: rtl/act_sram_ctrl.sv
// Activation SRAM sequencer: arbitrates PIP write-back, host loads and CIM
// row-read bursts onto the single SRAM port and tags the returning rows.
module act_sram_ctrl #(
  parameter int AW     = 5,
  parameter int HOST_W = 32,
  parameter int WB_W   = 256,
  parameter int ROW_W  = 768
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic [AW-1:0]     host_row,
  input  logic [AW-1:0]     host_col,
  input  logic [HOST_W-1:0] host_data,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [AW-1:0]     wb_row,
  input  logic [1:0]        wb_seg,
  input  logic [WB_W-1:0]   wb_data,
  input  logic              rd_start,
  input  logic [AW-1:0]     rd_base,
  input  logic [5:0]        rd_len,
  output logic              rd_busy,
  output logic              rd_data_valid,
  output logic [AW-1:0]     rd_row_idx,
  output logic [ROW_W-1:0]  rd_data,
  output logic              rd_done,
  output logic              addr_err,
  output logic              sram_ceb,
  output logic              sram_web,
  output logic              sram_wb_from_pip,
  output logic [AW-1:0]     sram_a_row,
  output logic [AW-1:0]     sram_a_col,
  output logic [WB_W-1:0]   sram_d,
  input  logic [ROW_W-1:0]  sram_q
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              ptr_host_q, ptr_host_d;
  logic [AW-1:0]     rd_row_q, rd_row_d;
  logic [5:0]        rd_left_q, rd_left_d;
  logic              done0_q, done0_d;
  logic              t1_v_q, t1_v_d;
  logic [AW-1:0]     t1_row_q, t1_row_d;
  logic              t1_last_q, t1_last_d;
  logic              t2_v_q;
  logic [AW-1:0]     t2_row_q;
  logic              t2_last_q;
  logic              ceb_q, ceb_d;
  logic              web_q, web_d;
  logic              wbp_q, wbp_d;
  logic [AW-1:0]     a_row_q, a_row_d;
  logic [AW-1:0]     a_col_q, a_col_d;
  logic [WB_W-1:0]   d_q, d_d;
  logic              err_q, err_d;

  logic rd_req, gnt_wb, gnt_host, gnt_rd;
  logic wb_bad, host_bad;

  assign wb_bad   = wb_seg == 2'd3;
  assign host_bad = host_col > AW'(23);
  assign rd_req   = state_q == BURST;

  // wb always wins; otherwise the pointer picks between read and host
  assign gnt_wb   = wb_valid;
  assign gnt_host = !wb_valid && host_valid && (!rd_req || ptr_host_q);
  assign gnt_rd   = !wb_valid && rd_req && (!host_valid || !ptr_host_q);

  assign wb_ready      = gnt_wb;
  assign host_ready    = gnt_host;
  assign rd_busy       = state_q != IDLE;
  assign rd_data_valid = t2_v_q;
  assign rd_row_idx    = t2_row_q;
  assign rd_data       = sram_q;
  assign rd_done       = (t2_v_q && t2_last_q) || done0_q;
  assign addr_err      = err_q;

  assign sram_ceb         = ceb_q;
  assign sram_web         = web_q;
  assign sram_wb_from_pip = wbp_q;
  assign sram_a_row       = a_row_q;
  assign sram_a_col       = a_col_q;
  assign sram_d           = d_q;

  always_comb begin
    state_d    = state_q;
    ptr_host_d = ptr_host_q;
    rd_row_d   = rd_row_q;
    rd_left_d  = rd_left_q;
    done0_d    = 1'b0;
    t1_v_d     = 1'b0;
    t1_row_d   = rd_row_q;
    t1_last_d  = rd_left_q == 6'd1;
    ceb_d      = 1'b1;
    web_d      = 1'b1;
    wbp_d      = 1'b0;
    a_row_d    = a_row_q;
    a_col_d    = a_col_q;
    d_d        = d_q;
    err_d      = err_q;

    unique case (1'b1)
      gnt_wb: begin
        if (wb_bad) begin
          err_d = 1'b1;
        end else begin
          ceb_d   = 1'b0;
          web_d   = 1'b0;
          wbp_d   = 1'b1;
          a_row_d = wb_row;
          a_col_d = AW'(wb_seg);
          d_d     = wb_data;
        end
      end
      gnt_host: begin
        ptr_host_d = 1'b0;
        if (host_bad) begin
          err_d = 1'b1;
        end else begin
          ceb_d   = 1'b0;
          web_d   = 1'b0;
          a_row_d = host_row;
          a_col_d = host_col;
          d_d     = WB_W'(host_data);
        end
      end
      gnt_rd: begin
        ptr_host_d = 1'b1;
        ceb_d      = 1'b0;
        a_row_d    = rd_row_q;
        t1_v_d     = 1'b1;
      end
      default: ;
    endcase

    unique case (state_q)
      IDLE: begin
        if (rd_start) begin
          if (rd_len == 6'd0) begin
            state_d = DRAIN;
            done0_d = 1'b1;
          end else begin
            state_d   = BURST;
            rd_row_d  = rd_base;
            rd_left_d = (rd_len > 6'd32) ? 6'd32 : rd_len;
          end
        end
      end
      BURST: begin
        if (gnt_rd) begin
          rd_row_d  = rd_row_q + AW'(1);
          rd_left_d = rd_left_q - 6'd1;
          if (rd_left_q == 6'd1) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (rd_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_host_q <= 1'b0;
      rd_row_q   <= '0;
      rd_left_q  <= '0;
      done0_q    <= 1'b0;
      t1_v_q     <= 1'b0;
      t1_row_q   <= '0;
      t1_last_q  <= 1'b0;
      t2_v_q     <= 1'b0;
      t2_row_q   <= '0;
      t2_last_q  <= 1'b0;
      ceb_q      <= 1'b1;
      web_q      <= 1'b1;
      wbp_q      <= 1'b0;
      a_row_q    <= '0;
      a_col_q    <= '0;
      d_q        <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_host_q <= ptr_host_d;
      rd_row_q   <= rd_row_d;
      rd_left_q  <= rd_left_d;
      done0_q    <= done0_d;
      t1_v_q     <= t1_v_d;
      t1_row_q   <= t1_row_d;
      t1_last_q  <= t1_last_d;
      t2_v_q     <= t1_v_q;
      t2_row_q   <= t1_row_q;
      t2_last_q  <= t1_last_q;
      ceb_q      <= ceb_d;
      web_q      <= web_d;
      wbp_q      <= wbp_d;
      a_row_q    <= a_row_d;
      a_col_q    <= a_col_d;
      d_q        <= d_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_act_sram_ctrl.sv
// Bench for act_sram_ctrl: SRAM device model, reference memory with a
// grant-order scoreboard, directed scenarios and a randomized phase.
module tb_act_sram_ctrl;
  localparam int AW = 5;
  localparam int HW = 32;
  localparam int WW = 256;
  localparam int RW = 768;

  logic          clk = 1'b0;
  logic          rst;
  logic          host_valid, host_ready;
  logic [AW-1:0] host_row, host_col;
  logic [HW-1:0] host_data;
  logic          wb_valid, wb_ready;
  logic [AW-1:0] wb_row;
  logic [1:0]    wb_seg;
  logic [WW-1:0] wb_data;
  logic          rd_start;
  logic [AW-1:0] rd_base;
  logic [5:0]    rd_len;
  logic          rd_busy, rd_data_valid, rd_done, addr_err;
  logic [AW-1:0] rd_row_idx;
  logic [RW-1:0] rd_data;
  logic          sram_ceb, sram_web, sram_wb_from_pip;
  logic [AW-1:0] sram_a_row, sram_a_col;
  logic [WW-1:0] sram_d;
  logic [RW-1:0] sram_q;

  always #5 clk = ~clk;

  act_sram_ctrl dut (
    .clk(clk), .rst(rst),
    .host_valid(host_valid), .host_ready(host_ready),
    .host_row(host_row), .host_col(host_col), .host_data(host_data),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_row(wb_row), .wb_seg(wb_seg), .wb_data(wb_data),
    .rd_start(rd_start), .rd_base(rd_base), .rd_len(rd_len),
    .rd_busy(rd_busy), .rd_data_valid(rd_data_valid),
    .rd_row_idx(rd_row_idx), .rd_data(rd_data), .rd_done(rd_done),
    .addr_err(addr_err),
    .sram_ceb(sram_ceb), .sram_web(sram_web),
    .sram_wb_from_pip(sram_wb_from_pip),
    .sram_a_row(sram_a_row), .sram_a_col(sram_a_col),
    .sram_d(sram_d), .sram_q(sram_q)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [RW-1:0] a,
                     input logic [RW-1:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time, a, e);
    end
  endtask

  // SRAM device: registered Q, writes by 32-bit word or 256-bit segment
  logic [RW-1:0] smem [32];
  logic [RW-1:0] sq = '0;
  assign sram_q = sq;

  initial forever begin
    @(posedge clk);
    if (!sram_ceb) begin
      if (!sram_web) begin
        if (sram_wb_from_pip)
          smem[sram_a_row][sram_a_col[1:0]*256 +: 256] = sram_d;
        else
          smem[sram_a_row][sram_a_col*32 +: 32] = sram_d[31:0];
      end else begin
        sq = smem[sram_a_row];
      end
    end
  end

  // Reference: memory contents as of each grant, in grant order
  typedef struct {
    logic [AW-1:0] row;
    logic [RW-1:0] data;
  } exp_t;

  logic [RW-1:0] rmem [32];
  exp_t          scq[$];
  exp_t          mon_e;

  int   m_cyc = 0;
  int   m_done_at = -10;
  int   m_pend = 0;
  int   m_n = 0;
  int   m_row = 0;
  bit   m_host_next = 0;
  bit   m_err = 0;
  bit   m_prev_issue = 0;
  bit   m_busy, m_gw, m_gh, m_gr, m_issue;

  initial forever begin
    @(negedge clk);
    m_cyc++;
    if (rst) begin
      m_done_at    = -10;
      m_pend       = 0;
      m_host_next  = 0;
      m_err        = 0;
      m_prev_issue = 0;
      scq.delete();
    end else begin
      m_busy = (m_pend > 0) || (m_cyc <= m_done_at);
      chk("rd_busy", rd_busy, m_busy);
      chk("rd_done", rd_done, m_cyc == m_done_at);
      chk("sram_ceb", sram_ceb, !m_prev_issue);
      chk("addr_err", addr_err, m_err);

      m_gw = wb_valid;
      m_gh = 0;
      m_gr = 0;
      if (!m_gw) begin
        if (m_pend > 0 && host_valid) begin
          if (m_host_next) m_gh = 1;
          else m_gr = 1;
        end else if (m_pend > 0) begin
          m_gr = 1;
        end else if (host_valid) begin
          m_gh = 1;
        end
      end
      chk("wb_ready", wb_ready, m_gw);
      chk("host_ready", host_ready, m_gh);

      m_issue = 0;
      if (m_gw) begin
        if (wb_seg < 3) begin
          rmem[wb_row][wb_seg*256 +: 256] = wb_data;
          m_issue = 1;
        end else m_err = 1;
      end
      if (m_gh) begin
        m_host_next = 0;
        if (host_col < 24) begin
          rmem[host_row][host_col*32 +: 32] = host_data;
          m_issue = 1;
        end else m_err = 1;
      end
      if (m_gr) begin
        m_host_next = 1;
        scq.push_back('{row: AW'(m_row), data: rmem[m_row]});
        m_issue = 1;
        m_row = (m_row + 1) % 32;
        m_pend--;
        if (m_pend == 0) m_done_at = m_cyc + 2;
      end

      if (rd_start && !m_busy) begin
        m_n = (rd_len > 32) ? 32 : int'(rd_len);
        if (m_n == 0) m_done_at = m_cyc + 1;
        else begin
          m_pend = m_n;
          m_row  = int'(rd_base);
        end
      end
      m_prev_issue = m_issue;
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst && rd_data_valid) begin
      if (scq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rd_extra t=%0t got row=%0d want none",
                 $time, rd_row_idx);
      end else begin
        mon_e = scq.pop_front();
        chk("rd_row_idx", rd_row_idx, mon_e.row);
        chk("rd_data", rd_data, mon_e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rdv(output bit got, output logic [RW-1:0] d,
                          output logic [AW-1:0] r, output logic dn);
    got = 0;
    d   = '0;
    r   = '0;
    dn  = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rd_data_valid) begin
        got = 1;
        d   = rd_data;
        r   = rd_row_idx;
        dn  = rd_done;
        break;
      end
    end
    tick();
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      if (!rd_busy) begin
        ok = 1;
        break;
      end
      tick();
    end
    chk("idle_timeout", ok, 1'b1);
  endtask

  task automatic start_rd(input int base, input int len);
    rd_start = 1;
    rd_base  = AW'(base);
    rd_len   = 6'(len);
    tick();
    rd_start = 0;
  endtask

  bit            got;
  logic [RW-1:0] gd;
  logic [AW-1:0] gr;
  logic          gdn;
  logic [511:0]  lo;

  initial begin
    for (int r = 0; r < 32; r++) begin
      for (int w = 0; w < 24; w++) smem[r][w*32 +: 32] = $urandom;
      rmem[r] = smem[r];
    end
    rst = 1;
    host_valid = 0; host_row = '0; host_col = '0; host_data = '0;
    wb_valid = 0; wb_row = '0; wb_seg = '0; wb_data = '0;
    rd_start = 0; rd_base = '0; rd_len = '0;
    #1;
    chk("rst_ceb", sram_ceb, 1'b1);
    chk("rst_web", sram_web, 1'b1);
    chk("rst_wbp", sram_wb_from_pip, 1'b0);
    chk("rst_arow", sram_a_row, '0);
    chk("rst_d", sram_d, '0);
    chk("rst_busy", rd_busy, 1'b0);
    chk("rst_valid", rd_data_valid, 1'b0);
    chk("rst_err", addr_err, 1'b0);
    tick();
    tick();
    rst = 0;
    tick();

    // host word then single-row read of it
    host_valid = 1; host_row = 5'd3; host_col = 5'd5;
    host_data = 32'hDEADBEEF;
    tick();
    host_valid = 0;
    start_rd(3, 1);
    wait_rdv(got, gd, gr, gdn);
    chk("t1_got", got, 1'b1);
    chk("t1_row", gr, 5'd3);
    chk("t1_word", gd[191:160], 32'hDEADBEEF);
    chk("t1_done", gdn, 1'b1);
    wait_idle();

    // write-back segment 2 of row 7
    lo = rmem[7][511:0];
    wb_valid = 1; wb_row = 5'd7; wb_seg = 2'd2; wb_data = '1;
    tick();
    wb_valid = 0;
    start_rd(7, 1);
    wait_rdv(got, gd, gr, gdn);
    chk("t2_got", got, 1'b1);
    chk("t2_hi", gd[767:512], {256{1'b1}});
    chk("t2_lo", gd[511:0], lo);
    wait_idle();

    // wrapping burst with host contention
    host_valid = 1; host_row = 5'd20; host_col = 5'd0;
    host_data = $urandom;
    start_rd(30, 4);
    for (int i = 0; i < 10; i++) begin
      host_row = AW'($urandom_range(31));
      host_col = AW'($urandom_range(23));
      host_data = $urandom;
      tick();
    end
    host_valid = 0;
    wait_idle();

    // all three requesters in one cycle
    start_rd(10, 2);
    wb_valid = 1; wb_row = 5'd10; wb_seg = 2'd0;
    wb_data = {8{$urandom}};
    host_valid = 1; host_row = 5'd11; host_col = 5'd0;
    host_data = $urandom;
    #1;
    chk("t4_wb", wb_ready, 1'b1);
    chk("t4_host", host_ready, 1'b0);
    tick();
    wb_valid = 0;
    repeat (4) tick();
    host_valid = 0;
    wait_idle();

    // dropped bad addresses and zero-length burst
    wb_valid = 1; wb_seg = 2'd3; wb_row = 5'd1;
    #1;
    chk("t5_wb_rdy", wb_ready, 1'b1);
    tick();
    wb_valid = 0;
    host_valid = 1; host_col = 5'd24; host_row = 5'd2;
    #1;
    chk("t5_host_rdy", host_ready, 1'b1);
    tick();
    host_valid = 0;
    chk("t5_ceb", sram_ceb, 1'b1);
    chk("t5_err", addr_err, 1'b1);
    start_rd(4, 0);
    chk("t5_done", rd_done, 1'b1);
    chk("t5_busy", rd_busy, 1'b1);
    chk("t5_novalid", rd_data_valid, 1'b0);
    tick();
    chk("t5_done_end", rd_done, 1'b0);
    chk("t5_idle", rd_busy, 1'b0);

    // reset mid-burst
    start_rd(0, 8);
    repeat (3) tick();
    rst = 1;
    #1;
    chk("t6_ceb", sram_ceb, 1'b1);
    chk("t6_busy", rd_busy, 1'b0);
    chk("t6_valid", rd_data_valid, 1'b0);
    chk("t6_err", addr_err, 1'b0);
    tick();
    tick();
    rst = 0;
    for (int i = 0; i < 6; i++) begin
      chk("t6_quiet", rd_data_valid, 1'b0);
      tick();
    end
    start_rd(5, 3);
    wait_idle();

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      wb_valid = ($urandom_range(7) == 0);
      wb_row   = AW'($urandom_range(31));
      wb_seg   = ($urandom_range(15) == 0) ? 2'd3 : 2'($urandom_range(2));
      wb_data  = {8{$urandom}};
      host_valid = $urandom_range(1) == 1;
      host_row   = AW'($urandom_range(31));
      host_col   = ($urandom_range(9) == 0) ?
                   AW'(24 + $urandom_range(7)) : AW'($urandom_range(23));
      host_data  = $urandom;
      rd_start = ($urandom_range(5) == 0);
      rd_base  = AW'($urandom_range(31));
      rd_len   = ($urandom_range(19) == 0) ?
                 6'(33 + $urandom_range(30)) : 6'($urandom_range(9));
      tick();
    end
    wb_valid = 0;
    host_valid = 0;
    rd_start = 0;
    wait_idle();
    repeat (4) tick();
    chk("sb_empty", scq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
